// File: rtl/dvp_frame_tx.sv
// DVP camera-side transmitter: streams 32-bit frame-buffer words as MSB-first pixel bytes
// with PCLK = clk/2 and VSYNC/HREF framing, one frame per start request.
module dvp_frame_tx #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 4,
    parameter int unsigned VLEAD      = 2,
    parameter int unsigned HBLANK     = 2,
    parameter int unsigned VTRAIL     = 1
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [10:0] base_adr_i,
    output logic [10:0] RAM_ADR_o,
    input  logic [31:0] RAM_DAT_i,
    output logic        PCLKO,
    output logic        VSYNCO,
    output logic        HREFO,
    output logic [7:0]  CAM_DATO,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned LINE_BYTES  = 4 * LINE_WORDS;
    localparam int unsigned TOTAL_WORDS = LINE_WORDS * LINES;
    localparam int unsigned MAX_A       = (VLEAD > LINE_BYTES) ? VLEAD : LINE_BYTES;
    localparam int unsigned MAX_B       = (HBLANK > MAX_A) ? HBLANK : MAX_A;
    localparam int unsigned CNT_MAX     = (VTRAIL > MAX_B) ? VTRAIL : MAX_B;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
    localparam int unsigned LINE_W      = $clog2(LINES + 1);
    localparam int unsigned WCNT_W      = $clog2(TOTAL_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StActive,
        StBlank,
        StTrail
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LINE_W-1:0]   r_line;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [23:0]         r_word;
    logic [10:0]         r_adr;
    logic                r_pclk;
    logic                r_vsync;
    logic                r_href;
    logic [7:0]          r_dat;
    logic                r_busy;
    logic                r_done;
    logic [15:0]         r_frame_cnt;

    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_last_word;
    logic [10:0]         w_adr_nxt;

    assign w_cnt_nxt   = r_cnt + CNT_W'(1);
    assign w_last_word = (r_wcnt == WCNT_W'(TOTAL_WORDS - 1));
    // The address is held on the final word so the read port stops at the frame's last word.
    assign w_adr_nxt   = w_last_word ? r_adr : r_adr + 11'd1;

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_line      <= '0;
            r_wcnt      <= '0;
            r_word      <= '0;
            r_adr       <= '0;
            r_pclk      <= 1'b0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_dat       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == StIdle) begin
                if (start_i) begin
                    r_state <= StLead;
                    r_busy  <= 1'b1;
                    r_vsync <= 1'b1;
                    r_pclk  <= 1'b0;
                    r_href  <= 1'b0;
                    r_dat   <= '0;
                    r_cnt   <= '0;
                    r_line  <= '0;
                    r_wcnt  <= '0;
                    r_adr   <= base_adr_i;
                end
            end else if (abort_i) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_vsync <= 1'b0;
                r_href  <= 1'b0;
                r_dat   <= '0;
                r_pclk  <= 1'b0;
            end else if (!r_pclk) begin
                r_pclk <= 1'b1;
            end else begin
                // Falling PCLK edge: byte-period boundary, all video outputs advance here.
                r_pclk <= 1'b0;
                case (r_state)
                    StLead: begin
                        if (r_cnt == CNT_W'(VLEAD - 1)) begin
                            r_state <= StActive;
                            r_cnt   <= '0;
                            r_href  <= 1'b1;
                            r_dat   <= RAM_DAT_i[31:24];
                            r_word  <= RAM_DAT_i[23:0];
                            r_wcnt  <= r_wcnt + WCNT_W'(1);
                            r_adr   <= w_adr_nxt;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                    StActive: begin
                        if (r_cnt == CNT_W'(LINE_BYTES - 1)) begin
                            r_cnt  <= '0;
                            r_href <= 1'b0;
                            r_dat  <= '0;
                            if (r_line != LINE_W'(LINES - 1)) begin
                                r_state <= StBlank;
                            end else if (VTRAIL != 0) begin
                                r_state <= StTrail;
                            end else begin
                                r_state     <= StIdle;
                                r_busy      <= 1'b0;
                                r_vsync     <= 1'b0;
                                r_done      <= 1'b1;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                        end else begin
                            r_cnt <= w_cnt_nxt;
                            if (w_cnt_nxt[1:0] == 2'd0) begin
                                r_dat  <= RAM_DAT_i[31:24];
                                r_word <= RAM_DAT_i[23:0];
                                r_wcnt <= r_wcnt + WCNT_W'(1);
                                r_adr  <= w_adr_nxt;
                            end else begin
                                case (w_cnt_nxt[1:0])
                                    2'd1:    r_dat <= r_word[23:16];
                                    2'd2:    r_dat <= r_word[15:8];
                                    default: r_dat <= r_word[7:0];
                                endcase
                            end
                        end
                    end
                    StBlank: begin
                        if (r_cnt == CNT_W'(HBLANK - 1)) begin
                            r_state <= StActive;
                            r_cnt   <= '0;
                            r_line  <= r_line + LINE_W'(1);
                            r_href  <= 1'b1;
                            r_dat   <= RAM_DAT_i[31:24];
                            r_word  <= RAM_DAT_i[23:0];
                            r_wcnt  <= r_wcnt + WCNT_W'(1);
                            r_adr   <= w_adr_nxt;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                    StTrail: begin
                        if (r_cnt == CNT_W'(VTRAIL - 1)) begin
                            r_state     <= StIdle;
                            r_busy      <= 1'b0;
                            r_vsync     <= 1'b0;
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_vsync <= 1'b0;
                        r_href  <= 1'b0;
                        r_dat   <= '0;
                    end
                endcase
            end
        end
    end

    assign RAM_ADR_o    = r_adr;
    assign PCLKO        = r_pclk;
    assign VSYNCO       = r_vsync;
    assign HREFO        = r_href;
    assign CAM_DATO     = r_dat;
    assign busy_o       = r_busy;
    assign frame_done_o = r_done;
    assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Bench for dvp_frame_tx: frame-timing reference model checked every cycle, a capture-side
// loopback, and directed plus randomized frames.
module tb_dvp_frame_tx;

    localparam int LW = 2;
    localparam int LN = 2;
    localparam int VL = 2;
    localparam int HB = 3;
    localparam int VT = 1;
    localparam int B  = 4 * LW;
    localparam int NW = LW * LN;
    localparam int N  = VL + B * LN + HB * (LN - 1) + VT;

    localparam logic [7:0] EXPB [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                          8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] base = '0;
    logic [10:0] ram_adr;
    logic [31:0] ram_q;
    logic        pclk, vsync, href, busy, done;
    logic [7:0]  dat;
    logic [15:0] fcnt;

    logic [31:0] mem [0:2047];
    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    dvp_frame_tx #(
        .LINE_WORDS(LW), .LINES(LN), .VLEAD(VL), .HBLANK(HB), .VTRAIL(VT)
    ) dut (
        .WBs_CLK_i   (clk),
        .WBs_RST_i   (rst),
        .start_i     (start),
        .abort_i     (abort),
        .base_adr_i  (base),
        .RAM_ADR_o   (ram_adr),
        .RAM_DAT_i   (ram_q),
        .PCLKO       (pclk),
        .VSYNCO      (vsync),
        .HREFO       (href),
        .CAM_DATO    (dat),
        .busy_o      (busy),
        .frame_done_o(done),
        .frame_cnt_o (fcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_adr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame position in clocks since the start edge.
    int          m_c = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [10:0] m_base = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = '0;
            m_c    = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_c    = 0;
                m_base = base;
            end
        end else begin
            m_done = 1'b0;
            if (abort) begin
                m_busy = 1'b0;
            end else begin
                m_c++;
                if (m_c == 2 * N) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_cnt++;
                end
            end
        end
    end

    function automatic logic [8:0] exp_video(input int c, input logic [10:0] b);
        int p, q, line, pos, idx;
        logic [31:0] w;
        p = c / 2;
        if (p < VL) return 9'd0;
        q    = p - VL;
        line = q / (B + HB);
        pos  = q % (B + HB);
        if (line >= LN || pos >= B) return 9'd0;
        idx = line * B + pos;
        w   = mem[b + 11'(idx / 4)];
        return {1'b1, 8'(w >> (8 * (3 - idx % 4)))};
    endfunction

    always @(negedge clk) begin
        logic [8:0] v;
        if (cmp_en) begin
            v = m_busy ? exp_video(m_c, m_base) : 9'd0;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("pclk", 32'(pclk), 32'(m_busy & (m_c % 2 == 1)));
            chk("vsync", 32'(vsync), 32'(m_busy));
            chk("href", 32'(href), 32'(v[8]));
            chk("data", 32'(dat), 32'(v[7:0]));
            chk("done", 32'(done), 32'(m_done));
            chk("fcnt", 32'(fcnt), 32'(m_cnt));
        end
    end

    // Capture-side loopback: sample on PCLK rise while frame and line are valid.
    logic [7:0] cap_bytes [$];
    always @(posedge pclk) begin
        if (vsync === 1'b1 && href === 1'b1) cap_bytes.push_back(dat);
    end

    int          r_busy_cyc, r_dones, r_b0, r_tend;
    bit          r_aborted;
    logic [10:0] adr_q [$];

    task automatic run_frame(input logic [10:0] b, input int pulse_at, input int abort_at);
        int t;
        adr_q.delete();
        r_b0 = cap_bytes.size();
        r_busy_cyc = 0;
        r_dones = 0;
        r_aborted = 0;
        @(negedge clk);
        base  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (t < 300) begin
            if (busy) begin
                r_busy_cyc++;
                if (adr_q.size() == 0 || adr_q[$] != ram_adr) adr_q.push_back(ram_adr);
            end
            if (done) begin
                r_dones++;
                break;
            end
            if (r_aborted && !busy) break;
            start = (t == pulse_at);
            abort = (t == abort_at);
            if (t == abort_at) r_aborted = 1;
            @(negedge clk);
            t++;
            start = 1'b0;
            abort = 1'b0;
        end
        r_tend = t;
        if (t >= 300) chk("frame_timeout", 32'(t), 32'(0));
    endtask

    task automatic check_words(input logic [10:0] b);
        logic [31:0] w;
        chk("cap_count", 32'(cap_bytes.size() - r_b0), 32'(4 * NW));
        for (int i = 0; i < NW; i++) begin
            if (r_b0 + 4 * i + 3 < cap_bytes.size()) begin
                w = {cap_bytes[r_b0 + 4 * i], cap_bytes[r_b0 + 4 * i + 1],
                     cap_bytes[r_b0 + 4 * i + 2], cap_bytes[r_b0 + 4 * i + 3]};
                chk("cap_word", w, mem[b + 11'(i)]);
            end
        end
    endtask

    initial begin
        int exp_cnt;
        int nd;
        int t;
        int dpos [3];
        int pa, ab;
        logic [10:0] rb;

        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        mem[2] = 32'h99AABBCC;
        mem[3] = 32'hDDEEFF00;

        start = 1'b1;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        chk("reset_adr", 32'(ram_adr), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Directed frame from the test plan.
        run_frame(11'd0, -1, -1);
        chk("dir_busy_clocks", 32'(r_busy_cyc), 32'(44));
        chk("dir_done_pulses", 32'(r_dones), 32'(1));
        chk("dir_fcnt", 32'(fcnt), 32'(1));
        chk("dir_nbytes", 32'(cap_bytes.size() - r_b0), 32'(16));
        for (int i = 0; i < 16; i++)
            if (r_b0 + i < cap_bytes.size()) chk("dir_byte", 32'(cap_bytes[r_b0 + i]), 32'(EXPB[i]));
        check_words(11'd0);

        // Address wrap at the top of the RAM.
        run_frame(11'd2046, -1, -1);
        chk("wrap_nadr", 32'(adr_q.size()), 32'(4));
        if (adr_q.size() == 4) begin
            chk("wrap_adr0", 32'(adr_q[0]), 32'(2046));
            chk("wrap_adr1", 32'(adr_q[1]), 32'(2047));
            chk("wrap_adr2", 32'(adr_q[2]), 32'(0));
            chk("wrap_adr3", 32'(adr_q[3]), 32'(1));
        end
        check_words(11'd2046);
        chk("wrap_fcnt", 32'(fcnt), 32'(2));

        // Abort during the fifth active byte, then a full frame.
        run_frame(11'd0, -1, 12);
        chk("abort_done", 32'(r_dones), 32'(0));
        chk("abort_latency", 32'(r_tend - 12), 32'(1));
        chk("abort_fcnt", 32'(fcnt), 32'(2));
        chk("abort_bytes", 32'(cap_bytes.size() - r_b0), 32'(4));
        run_frame(11'd0, -1, -1);
        check_words(11'd0);
        chk("post_abort_fcnt", 32'(fcnt), 32'(3));

        // Reset in the middle of line blanking, with start held through reset.
        @(negedge clk);
        base  = 11'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_vsync", 32'(vsync), 32'(0));
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_idle_busy", 32'(busy), 32'(0));
        chk("rst_fcnt", 32'(fcnt), 32'(0));
        chk("rst_adr", 32'(ram_adr), 32'(0));
        run_frame(11'd0, -1, -1);
        check_words(11'd0);
        chk("post_rst_fcnt", 32'(fcnt), 32'(1));

        // Start pulse while busy must not restart the frame.
        run_frame(11'd0, 10, -1);
        chk("pulse_busy_clocks", 32'(r_busy_cyc), 32'(44));
        check_words(11'd0);
        exp_cnt = 2;

        // Randomized frames: random base, RAM contents, mid-frame start pulses and aborts.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 2048; i++) mem[i] = $urandom;
            rb = 11'($urandom);
            pa = $urandom_range(1, 40);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * N - 1) : -1;
            run_frame(rb, pa, ab);
            if (ab < 0) begin
                exp_cnt++;
                chk("rnd_busy_clocks", 32'(r_busy_cyc), 32'(2 * N));
                check_words(rb);
            end else begin
                chk("rnd_abort_done", 32'(r_dones), 32'(0));
            end
            chk("rnd_fcnt", 32'(fcnt), 32'(exp_cnt));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Start held high: back-to-back frames with one idle clock between them.
        @(negedge clk);
        base  = 11'd5;
        start = 1'b1;
        nd = 0;
        t  = 0;
        while (nd < 3 && t < 400) begin
            @(negedge clk);
            t++;
            if (done) begin
                dpos[nd] = t;
                nd++;
            end
        end
        start = 1'b0;
        chk("held_frames", 32'(nd), 32'(3));
        if (nd == 3) begin
            chk("held_gap1", 32'(dpos[1] - dpos[0]), 32'(2 * N + 1));
            chk("held_gap2", 32'(dpos[2] - dpos[1]), 32'(2 * N + 1));
        end
        repeat (3) @(negedge clk);
        chk("held_fcnt", 32'(fcnt), 32'(exp_cnt + 3));
        chk("held_idle", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
